// File: rtl/test_out_pkg.sv
// Shared definitions for the test output pin sequencer: mode codes, FSM states
// and default field widths.
package test_out_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_CONT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Reserved mode deliberately falls in with OFF.
    function automatic logic mode_runs(input logic [1:0] mode);
        case (mode)
            MODE_CONT, MODE_BURST: return 1'b1;
            MODE_OFF, MODE_RSVD:   return 1'b0;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/test_out_phase_cnt.sv
// Phase counter and pin toggle bit: each phase lasts load_val+1 cycles, and
// period_end marks the last cycle of the low phase.
module test_out_phase_cnt
    import test_out_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             phase_end_o,
    output logic             period_end_o,
    output logic             tog_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             tog_q;
    logic             phase_end_s;

    // Strobes only fire while the waveform is being counted.
    always_comb begin
        phase_end_s  = en_i && (cnt_q == {DIV_W{1'b0}});
        phase_end_o  = phase_end_s;
        period_end_o = phase_end_s && !tog_q;
        tog_o        = tog_q;
    end

    // Counter/toggle state: clear beats load, load beats free-running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {DIV_W{1'b0}};
            tog_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= {DIV_W{1'b0}};
            tog_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            tog_q <= 1'b1;
        end else if (en_i) begin
            if (phase_end_s) begin
                cnt_q <= load_val_i;
                tog_q <= ~tog_q;
            end else begin
                cnt_q <= cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/test_out_ctrl.sv
// Test output pin sequencer: accepts pin configurations over a valid/ready port
// and switches between them only at period boundaries.
module test_out_ctrl
    import test_out_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             test_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [1:0]       act_mode_q;
    logic [DIV_W-1:0] act_half_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [1:0]       shd_mode_q;
    logic [DIV_W-1:0] shd_half_q;
    logic [CNT_W-1:0] shd_count_q;
    logic             cfg_ready_q;
    logic             busy_q;
    logic             done_q;

    logic             accept_s;
    logic             apply_s;
    logic             src_runs_s;
    logic             burst_last_s;
    logic [1:0]       src_mode_s;
    logic [DIV_W-1:0] src_half_s;
    logic [CNT_W-1:0] src_count_s;
    logic             ph_en_s;
    logic             ph_load_s;
    logic             ph_clr_s;
    logic [DIV_W-1:0] ph_val_s;
    logic             phase_end_s;
    logic             period_end_s;
    logic             tog_s;

    // Decide when a configuration takes effect and steer the phase counter.
    // A request arriving in RUN exactly on a boundary cycle applies there.
    always_comb begin
        accept_s    = cfg_valid && cfg_ready_q;
        src_mode_s  = cfg_mode;
        src_half_s  = cfg_half;
        src_count_s = cfg_count;
        apply_s     = 1'b0;
        case (state_q)
            IDLE:  apply_s = accept_s;
            RUN:   apply_s = accept_s && period_end_s;
            DRAIN: begin
                apply_s     = period_end_s;
                src_mode_s  = shd_mode_q;
                src_half_s  = shd_half_q;
                src_count_s = shd_count_q;
            end
            default: apply_s = 1'b0;
        endcase
        src_runs_s   = mode_runs(src_mode_s);
        burst_last_s = period_end_s && (act_mode_q == MODE_BURST)
                       && (per_cnt_q == {CNT_W{1'b0}});
        ph_en_s      = (state_q == RUN) || (state_q == DRAIN);
        ph_load_s    = apply_s && src_runs_s;
        ph_clr_s     = (apply_s && !src_runs_s) || (burst_last_s && !apply_s);
        ph_val_s     = ph_load_s ? src_half_s : act_half_q;
    end

    test_out_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (ph_clr_s),
        .load_i       (ph_load_s),
        .en_i         (ph_en_s),
        .load_val_i   (ph_val_s),
        .phase_end_o  (phase_end_s),
        .period_end_o (period_end_s),
        .tog_o        (tog_s)
    );

    // Control FSM with active/shadow configuration and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_mode_q  <= MODE_OFF;
            act_half_q  <= {DIV_W{1'b0}};
            per_cnt_q   <= {CNT_W{1'b0}};
            shd_mode_q  <= MODE_OFF;
            shd_half_q  <= {DIV_W{1'b0}};
            shd_count_q <= {CNT_W{1'b0}};
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= burst_last_s;
            if (apply_s) begin
                cfg_ready_q <= 1'b1;
                if (src_runs_s) begin
                    state_q    <= RUN;
                    act_mode_q <= src_mode_s;
                    act_half_q <= src_half_s;
                    per_cnt_q  <= src_count_s;
                    busy_q     <= 1'b1;
                end else begin
                    state_q    <= IDLE;
                    act_mode_q <= MODE_OFF;
                    busy_q     <= 1'b0;
                end
            end else if (burst_last_s) begin
                state_q     <= IDLE;
                act_mode_q  <= MODE_OFF;
                cfg_ready_q <= 1'b1;
                busy_q      <= 1'b0;
            end else if ((state_q == RUN) && accept_s) begin
                state_q     <= DRAIN;
                shd_mode_q  <= cfg_mode;
                shd_half_q  <= cfg_half;
                shd_count_q <= cfg_count;
                cfg_ready_q <= 1'b0;
            end else if (period_end_s && (act_mode_q == MODE_BURST)
                         && (per_cnt_q != {CNT_W{1'b0}})) begin
                per_cnt_q <= per_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign test_out  = tog_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_test_out_ctrl.sv
// Directed bench for test_out_ctrl: per-cycle expectations of
// {test_out, busy, done, cfg_ready} are queued and checked each cycle.
module tb_test_out_ctrl;
    import test_out_pkg::*;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_mode;
    logic [DW-1:0] cfg_half;
    logic [CW-1:0] cfg_count;
    logic          test_out;
    logic          busy;
    logic          done;

    logic [3:0] exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    test_out_ctrl #(
        .DIV_W (DW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
        .cfg_count (cfg_count),
        .test_out  (test_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic push(input string tag, input logic t, input logic b,
                        input logic d, input logic r);
        exp_q.push_back({t, b, d, r});
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        logic [3:0] obs;
        logic [3:0] exp;
        string      tag;
        obs = {test_out, busy, done, cfg_ready};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed={t,b,d,r}=%b expected=queued entry", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed {t,b,d,r}=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    // Drive this cycle's config inputs, check this cycle's outputs, advance.
    task automatic step(input logic v, input logic [1:0] m,
                        input logic [DW-1:0] h, input logic [CW-1:0] c);
        cfg_valid = v;
        cfg_mode  = m;
        cfg_half  = h;
        cfg_count = c;
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        repeat (n) step(1'b0, MODE_OFF, 4'd0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = MODE_OFF;
        cfg_half = 4'd0; cfg_count = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        push("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check_now();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // CONT half=0: clk/2 from cycle 1, then stopped with OFF
        push("cont0_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) push("cont0_wave", (k % 2) == 1, 1'b1, 1'b0, 1'b1);
        push("cont0_offreq", 1'b1, 1'b1, 1'b0, 1'b1);
        push("cont0_drain", 1'b0, 1'b1, 1'b0, 1'b0);
        push("cont0_off", 1'b0, 1'b0, 1'b0, 1'b1);
        push("cont0_off2", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, MODE_CONT, 4'd0, 8'd0);
        nop(8);
        step(1'b1, MODE_OFF, 4'd0, 8'd0);
        nop(3);

        // BURST half=1 count=2: three periods, done at cycle 13
        push("burst_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++)
            push("burst_wave", (((k - 1) / 2) % 2) == 0, 1'b1, 1'b0, 1'b1);
        push("burst_done", 1'b0, 1'b0, 1'b1, 1'b1);
        push("burst_after", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, MODE_BURST, 4'd1, 8'd2);
        nop(14);

        // CONT half=3, retargeted to half=0 on the 2nd high cycle
        push("retgt_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        push("retgt_h1", 1'b1, 1'b1, 1'b0, 1'b1);
        push("retgt_h2", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 3; k <= 4; k++) push("retgt_drain_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 5; k <= 8; k++) push("retgt_drain_lo", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 9; k <= 12; k++) push("retgt_new", (k % 2) == 1, 1'b1, 1'b0, 1'b1);
        step(1'b1, MODE_CONT, 4'd3, 8'd0);
        nop(1);
        step(1'b1, MODE_CONT, 4'd0, 8'd0);
        nop(10);

        // Retarget to CONT half=2, then OFF mid-low phase
        push("off_req1", 1'b1, 1'b1, 1'b0, 1'b1);
        push("off_drain1", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 15; k <= 17; k++) push("off_hi", 1'b1, 1'b1, 1'b0, 1'b1);
        push("off_lo1", 1'b0, 1'b1, 1'b0, 1'b1);
        push("off_lo2_req", 1'b0, 1'b1, 1'b0, 1'b1);
        push("off_lo3_drain", 1'b0, 1'b1, 1'b0, 1'b0);
        push("off_idle1", 1'b0, 1'b0, 1'b0, 1'b1);
        push("off_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, MODE_CONT, 4'd2, 8'd0);
        nop(5);
        step(1'b1, MODE_OFF, 4'd0, 8'd0);
        nop(3);

        // BURST half=0 count=0 with CONT half=1 queued: shadow wins at the final boundary
        push("coin_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        push("coin_hi", 1'b1, 1'b1, 1'b0, 1'b1);
        push("coin_boundary", 1'b0, 1'b1, 1'b0, 1'b0);
        push("coin_done", 1'b1, 1'b1, 1'b1, 1'b1);
        push("coin_hi2", 1'b1, 1'b1, 1'b0, 1'b1);
        push("coin_lo1", 1'b0, 1'b1, 1'b0, 1'b1);
        push("coin_lo2", 1'b0, 1'b1, 1'b0, 1'b1);
        push("coin_hi3", 1'b1, 1'b1, 1'b0, 1'b1);
        push("coin_offreq", 1'b1, 1'b1, 1'b0, 1'b1);
        push("coin_drain1", 1'b0, 1'b1, 1'b0, 1'b0);
        push("coin_drain2", 1'b0, 1'b1, 1'b0, 1'b0);
        push("coin_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, MODE_BURST, 4'd0, 8'd0);
        step(1'b1, MODE_CONT, 4'd1, 8'd0);
        nop(6);
        step(1'b1, MODE_OFF, 4'd0, 8'd0);
        nop(3);

        // Reserved mode in IDLE is ignored
        push("rsvd_req", 1'b0, 1'b0, 1'b0, 1'b1);
        push("rsvd_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        push("rsvd_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, MODE_RSVD, 4'd1, 8'd0);
        nop(2);

        // Maximum phase: half all-ones gives 16-cycle phases
        push("max_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) push("max_hi", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 17; k <= 32; k++) push("max_lo", 1'b0, 1'b1, 1'b0, 1'b1);
        push("max_offreq", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 34; k <= 48; k++) push("max_drain_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 49; k <= 64; k++) push("max_drain_lo", 1'b0, 1'b1, 1'b0, 1'b0);
        push("max_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, MODE_CONT, 4'hF, 8'd0);
        nop(32);
        step(1'b1, MODE_OFF, 4'd0, 8'd0);
        nop(32);

        // BURST half=4 count=5, reset asserted mid-high phase
        push("rst_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        push("rst_hi1", 1'b1, 1'b1, 1'b0, 1'b1);
        push("rst_hi2", 1'b1, 1'b1, 1'b0, 1'b1);
        push("rst_pre", 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, MODE_BURST, 4'd4, 8'd5);
        nop(2);
        check_now();
        rst_n = 1'b0;
        #1;
        push("rst_async", 1'b0, 1'b0, 1'b0, 1'b1);
        check_now();
        repeat (2) begin
            @(posedge clk);
            #1;
            push("rst_hold", 1'b0, 1'b0, 1'b0, 1'b1);
            check_now();
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) push("rst_release", 1'b0, 1'b0, 1'b0, 1'b1);
        nop(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
